// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and its muldiv sequencer.
package hazard_pkg;

  localparam int unsigned MULDIV_LAT_MAX = 32;
  localparam int unsigned CNT_W          = 5;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_seq.sv
// Muldiv sequencer: start pulse, fixed-latency freeze, then a one-cycle result-select window.
module md_seq
  import hazard_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req,
  output logic o_md_stall,
  output logic o_start,
  output logic o_sel,
  output logic o_busy
);

  // Start cycle plus the terminal cnt==0 cycle account for the 2 subtracted here.
  localparam logic [CNT_W-1:0] CntInit =
    (MULDIV_LAT >= 2) ? CNT_W'(MULDIV_LAT - 2) : '0;

  md_state_e        r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_busy;

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    o_md_stall = 1'b0;
    o_start    = 1'b0;
    o_sel      = 1'b0;
    case (r_state)
      RUN: begin
        if (i_req) begin
          o_start    = 1'b1;
          o_md_stall = 1'b1;
          if (MULDIV_LAT == 1) begin
            w_state_d = MD_DONE;
          end else begin
            w_state_d = MD_BUSY;
            w_cnt_d   = CntInit;
          end
        end
      end
      MD_BUSY: begin
        o_md_stall = 1'b1;
        if (r_cnt == '0) begin
          w_state_d = MD_DONE;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      MD_DONE: begin
        o_sel     = 1'b1;
        w_state_d = RUN;
      end
      default: w_state_d = RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_busy  <= (w_state_d != RUN);
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller: load-use, taken-branch flush and muldiv freeze sequencing.
// Optional stall/flush performance counters are enabled by defining HAZARD_PERF_EN.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [4:0] IF_ID_RS1addr_i,
  input  logic [4:0] IF_ID_RS2addr_i,
  input  logic       ID_EX_MemRead_i,
  input  logic [4:0] ID_EX_RDaddr_i,
  input  logic       ID_EX_MulDiv_i,
  input  logic       Branch_taken_i,
  output logic       PC_write_o,
  output logic       IF_ID_write_o,
  output logic       IF_flush_o,
  output logic       ID_EX_bubble_o,
  output logic       ID_EX_write_o,
  output logic       EX_MEM_bubble_o,
  output logic       MulDiv_start_o,
  output logic       MulDiv_sel_o,
  output logic       MulDiv_busy_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] Stall_cnt_o,
  output logic [31:0] Flush_cnt_o
`endif
);

  logic w_md_stall;
  logic w_load_use;

  md_seq #(
    .MULDIV_LAT (MULDIV_LAT)
  ) u_md_seq (
    .i_clk      (clk_i),
    .i_rst_n    (rst_n_i),
    .i_req      (ID_EX_MulDiv_i),
    .o_md_stall (w_md_stall),
    .o_start    (MulDiv_start_o),
    .o_sel      (MulDiv_sel_o),
    .o_busy     (MulDiv_busy_o)
  );

  // Busy is high exactly when the sequencer is out of RUN; a muldiv in EX masks any load.
  always_comb begin
    w_load_use = !MulDiv_busy_o && !ID_EX_MulDiv_i && ID_EX_MemRead_i &&
                 (ID_EX_RDaddr_i != 5'd0) &&
                 ((ID_EX_RDaddr_i == IF_ID_RS1addr_i) || (ID_EX_RDaddr_i == IF_ID_RS2addr_i));
  end

  always_comb begin
    PC_write_o      = !(w_md_stall || w_load_use);
    IF_ID_write_o   = !(w_md_stall || w_load_use);
    IF_flush_o      = Branch_taken_i && !w_md_stall && !w_load_use;
    ID_EX_bubble_o  = w_load_use;
    ID_EX_write_o   = !w_md_stall;
    EX_MEM_bubble_o = w_md_stall;
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!PC_write_o && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (IF_flush_o && (r_flush_cnt != 32'hFFFF_FFFF)) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign Stall_cnt_o = r_stall_cnt;
  assign Flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: instances at MULDIV_LAT=4 and 1 checked against a cycle model.
module tb_pipeline_hazard_ctrl;

  localparam int Lat0 = 4;
  localparam int Lat1 = 1;
  localparam logic [8:0] VDef = 9'b110010000;
  localparam logic [8:0] VLu  = 9'b000110000;
  localparam logic [8:0] VBr  = 9'b111010000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       mr = 1'b0, md = 1'b0, br = 1'b0;

  logic [1:0] pcw, ifidw, flush, bub, idexw, exb, st, sel, busy;
`ifdef HAZARD_PERF_EN
  logic [31:0] scnt0, fcnt0, scnt1, fcnt1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_hazard_ctrl #(.MULDIV_LAT(Lat0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n),
    .IF_ID_RS1addr_i(rs1), .IF_ID_RS2addr_i(rs2), .ID_EX_MemRead_i(mr),
    .ID_EX_RDaddr_i(rd), .ID_EX_MulDiv_i(md), .Branch_taken_i(br),
    .PC_write_o(pcw[0]), .IF_ID_write_o(ifidw[0]), .IF_flush_o(flush[0]),
    .ID_EX_bubble_o(bub[0]), .ID_EX_write_o(idexw[0]), .EX_MEM_bubble_o(exb[0]),
    .MulDiv_start_o(st[0]), .MulDiv_sel_o(sel[0]), .MulDiv_busy_o(busy[0])
`ifdef HAZARD_PERF_EN
    , .Stall_cnt_o(scnt0), .Flush_cnt_o(fcnt0)
`endif
  );

  pipeline_hazard_ctrl #(.MULDIV_LAT(Lat1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n),
    .IF_ID_RS1addr_i(rs1), .IF_ID_RS2addr_i(rs2), .ID_EX_MemRead_i(mr),
    .ID_EX_RDaddr_i(rd), .ID_EX_MulDiv_i(md), .Branch_taken_i(br),
    .PC_write_o(pcw[1]), .IF_ID_write_o(ifidw[1]), .IF_flush_o(flush[1]),
    .ID_EX_bubble_o(bub[1]), .ID_EX_write_o(idexw[1]), .EX_MEM_bubble_o(exb[1]),
    .MulDiv_start_o(st[1]), .MulDiv_sel_o(sel[1]), .MulDiv_busy_o(busy[1])
`ifdef HAZARD_PERF_EN
    , .Stall_cnt_o(scnt1), .Flush_cnt_o(fcnt1)
`endif
  );

  // Model: cycles of freeze still owed after the start cycle, and a result-select flag.
  int          md_left[2];
  bit          md_done[2];
  logic [31:0] m_scnt[2];
  logic [31:0] m_fcnt[2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      md_left[k] = 0; md_done[k] = 1'b0; m_scnt[k] = '0; m_fcnt[k] = '0;
    end
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? Lat0 : Lat1;
  endfunction

  function automatic logic [8:0] dut_vec(input int k);
    return {pcw[k], ifidw[k], flush[k], bub[k], idexw[k], exb[k], st[k], sel[k], busy[k]};
  endfunction

  // {PC_write, IF_ID_write, IF_flush, ID_EX_bubble, ID_EX_write, EX_MEM_bubble, start, sel, busy}
  function automatic logic [8:0] model_vec(input int k);
    bit idle = (md_left[k] == 0) && !md_done[k];
    bit mds  = (idle && md) || (md_left[k] > 0);
    bit lu   = idle && !md && mr && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    return {!(mds || lu), !(mds || lu), br && !mds && !lu, lu, !mds, mds,
            idle && md, md_done[k], !idle};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        md_left[k] <= 0; md_done[k] <= 1'b0; m_scnt[k] <= '0; m_fcnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic [8:0] mv;
        mv = model_vec(k);
        if (!mv[8] && m_scnt[k] != 32'hFFFF_FFFF) m_scnt[k] <= m_scnt[k] + 1;
        if (mv[6] && m_fcnt[k] != 32'hFFFF_FFFF) m_fcnt[k] <= m_fcnt[k] + 1;
        if (md_left[k] == 0 && !md_done[k] && md) begin
          md_left[k] <= lat_of(k) - 1;
          md_done[k] <= (lat_of(k) == 1);
        end else if (md_left[k] > 0) begin
          md_left[k] <= md_left[k] - 1;
          md_done[k] <= (md_left[k] == 1);
        end else begin
          md_done[k] <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("model_dut%0d", k), 32'(dut_vec(k)), 32'(model_vec(k)));
    end
`ifdef HAZARD_PERF_EN
    check("model_stall_cnt0", scnt0, m_scnt[0]);
    check("model_flush_cnt0", fcnt0, m_fcnt[0]);
    check("model_stall_cnt1", scnt1, m_scnt[1]);
    check("model_flush_cnt1", fcnt1, m_fcnt[1]);
`endif
  end

  task automatic cyc(input logic md_v, input logic mr_v, input logic [4:0] rd_v,
                     input logic [4:0] rs1_v, input logic [4:0] rs2_v, input logic br_v);
    @(posedge clk);
    #1;
    md = md_v; mr = mr_v; rd = rd_v; rs1 = rs1_v; rs2 = rs2_v; br = br_v;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    md = 1'b0; mr = 1'b0; rd = '0; rs1 = '0; rs2 = '0; br = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int frozen, starts, sel_at, sels;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_defaults", 32'(dut_vec(0)), 32'(VDef));

    // Load-use on rs1 and rs2, then rd=0 exemption
    cyc(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
    check("lu_rs1_stall", 32'(dut_vec(0)), 32'(VLu));
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("lu_after", 32'(dut_vec(0)), 32'(VDef));
    cyc(1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0);
    check("lu_rs2_stall", 32'(dut_vec(0)), 32'(VLu));
    cyc(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    check("lu_rd0_none", 32'(dut_vec(0)), 32'(VDef));

    // Branch flush, suppressed by a load-use stall, then re-presented
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    check("br_flush", 32'(dut_vec(0)), 32'(VBr));
    cyc(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1);
    check("br_in_lu", 32'(dut_vec(0)), 32'(VLu));
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    check("br_replay", 32'(dut_vec(0)), 32'(VBr));
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

    // Single muldiv at LAT=4 (op held in EX while frozen); load also flagged at start
    frozen = 0; starts = 0; sel_at = -1;
    for (int c = 0; c < 7; c++) begin
      cyc(c <= 4, c == 0, 5'd5, 5'd5, 5'd0, 1'b0);
      if (c == 0) check("md_over_lu_bubble", 32'(bub[0]), 32'd0);
      if (!pcw[0]) frozen++;
      if (st[0]) starts++;
      if (sel[0]) sel_at = c;
      if (c == 1) check("md4_busy_c1", 32'(busy[0]), 32'd1);
      if (c == 4) check("md4_busy_c4", 32'(busy[0]), 32'd1);
      if (c == 5) check("md4_run_c5", 32'(dut_vec(0)), 32'(VDef));
    end
    check("md4_frozen", 32'(frozen), 32'd4);
    check("md4_starts", 32'(starts), 32'd1);
    check("md4_sel_cycle", 32'(sel_at), 32'd4);

    // Back-to-back muldiv: LAT=4 over 10 cycles, LAT=1 over its first 4
    frozen = 0; starts = 0; sels = 0;
    for (int c = 0; c < 12; c++) begin
      cyc(c <= 9, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      if (!pcw[0]) frozen++;
      if (st[0]) starts++;
      if (c == 0) check("lat1_frozen_c0", 32'(pcw[1]), 32'd0);
      if (c == 1) check("lat1_sel_c1", 32'({sel[1], pcw[1], st[1]}), 32'b110);
      if (c < 4) begin
        if (!pcw[1]) sels++;
      end
    end
    check("b2b4_frozen", 32'(frozen), 32'd8);
    check("b2b4_starts", 32'(starts), 32'd2);
    check("b2b1_frozen", 32'(sels), 32'd2);

    // Reset while in MD_BUSY
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("md_busy_before_rst", 32'(busy[0]), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    md = 1'b0;
    #1;
    check("rst_busy_defaults", 32'(dut_vec(0)), 32'(VDef));
    @(posedge clk);
    #1 rst_n = 1'b1;
    sels = 0;
    for (int c = 0; c < 6; c++) begin
      cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      if (sel[0]) sels++;
    end
    check("rst_no_sel", 32'(sels), 32'd0);
    cyc(1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0);
    check("rst_run_lu", 32'(dut_vec(0)), 32'(VLu));

`ifdef HAZARD_PERF_EN
    do_reset();
    check("perf_reset", scnt0 | fcnt0, 32'd0);
    cyc(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    for (int c = 0; c < 5; c++) cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("perf_stall_cnt", scnt0, 32'd5);
    check("perf_flush_cnt", fcnt0, 32'd2);
`endif

    do_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Stall/flush controller for the 5-stage pipeline. It sits beside the EX-stage forwarding unit and produces the freeze, bubble and flush strobes for PC, IF/ID, ID/EX and EX/MEM. It detects load-use hazards, flushes IF/ID on taken branches resolved in ID, and sequences the fixed-latency multi-cycle multiply/divide unit, holding the pipeline until its result is ready.

## Interface

Parameters:
- MULDIV_LAT, default 4: cycles from muldiv start to result valid; legal range 1..32.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- IF_ID_RS1addr_i  in  5  rs1 of the instruction in ID.
- IF_ID_RS2addr_i  in  5  rs2 of the instruction in ID.
- ID_EX_MemRead_i  in  1  instruction in EX is a load.
- ID_EX_RDaddr_i  in  5  rd of the instruction in EX.
- ID_EX_MulDiv_i  in  1  instruction in EX is a mul/div op.
- Branch_taken_i  in  1  branch in ID resolved taken.
- PC_write_o  out  1  PC may update.
- IF_ID_write_o  out  1  IF/ID may update.
- IF_flush_o  out  1  clear IF/ID to NOP on the next edge.
- ID_EX_bubble_o  out  1  load NOP into ID/EX on the next edge.
- ID_EX_write_o  out  1  ID/EX may update.
- EX_MEM_bubble_o  out  1  load NOP into EX/MEM on the next edge.
- MulDiv_start_o  out  1  one-cycle start pulse to the muldiv unit.
- MulDiv_sel_o  out  1  EX/MEM takes the muldiv result instead of the ALU result.
- MulDiv_busy_o  out  1  FSM is not in RUN.
- Stall_cnt_o  out  32  present only with HAZARD_PERF_EN.
- Flush_cnt_o  out  32  present only with HAZARD_PERF_EN.

## Operation

- FSM states: RUN, MD_BUSY, MD_DONE. The down-counter `cnt` is 5 bits wide.
- In RUN with ID_EX_MulDiv_i=1:
  - Assert MulDiv_start_o and the md-stall.
  - If MULDIV_LAT==1, next state is MD_DONE.
  - Otherwise, next state is MD_BUSY with cnt=MULDIV_LAT-2.
- In MD_BUSY:
  - md-stall is asserted.
  - If cnt==0, next state is MD_DONE; otherwise cnt decrements.
- In MD_DONE:
  - md-stall is deasserted and MulDiv_sel_o=1.
  - Next state is RUN unconditionally.
  - ID_EX_MulDiv_i is ignored this cycle, so back-to-back muldiv ops restart from RUN.
- md-stall effect: PC_write_o=0, IF_ID_write_o=0, ID_EX_write_o=0, EX_MEM_bubble_o=1.
- Load-use hazard (combinational, RUN only): ID_EX_MemRead_i && ID_EX_RDaddr_i!=0 && (ID_EX_RDaddr_i==IF_ID_RS1addr_i || ID_EX_RDaddr_i==IF_ID_RS2addr_i). Its effect is PC_write_o=0, IF_ID_write_o=0, ID_EX_bubble_o=1, ID_EX_write_o=1.
- Branch flush: IF_flush_o = Branch_taken_i && no stall of either kind this cycle. A branch that arrives during a stall is re-presented after the stall and is not lost.
- A load and a muldiv cannot both be in EX. If both inputs are asserted, the muldiv takes priority and the load-use hazard is ignored.
- Default outputs (no hazard): PC_write_o=1, IF_ID_write_o=1, ID_EX_write_o=1, all other strobes 0.

## Timing

- Reset (async assert, sync release):
  - state=RUN, cnt=0, counters=0.
  - Outputs take their default values immediately.
- Reset in MD_BUSY aborts the sequence with no MulDiv_sel_o pulse.
- Load-use: exactly 1 stall cycle per hazard; zero-cycle detection latency.
- Muldiv: the pipeline freezes for exactly MULDIV_LAT cycles: the start cycle plus MULDIV_LAT-1 in MD_BUSY. MD_DONE is the first non-frozen cycle and carries MulDiv_sel_o.
- MulDiv_start_o is high for exactly one cycle per op. MulDiv_busy_o is registered: high in MD_BUSY and MD_DONE.

## Configuration

- HAZARD_PERF_EN defined:
  - Stall_cnt_o increments on every cycle with PC_write_o=0.
  - Flush_cnt_o increments on every cycle with IF_flush_o=1.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: both ports and their registers are absent. All other behaviour is identical.

## Structure

- Shared package hazard_pkg:
  - state enum (RUN=2'd0, MD_BUSY=2'd1, MD_DONE=2'd2).
  - MULDIV_LAT_MAX=32 and CNT_W=5.
- One sub-module, md_seq, holds the FSM and counter and exports the md-stall, start, sel and busy signals. Load-use and branch logic stay in the top level.

## Test plan

- Load x5 in EX (rd=5), ID reads rs1=5 → one cycle of PC_write_o=0, ID_EX_bubble_o=1, then defaults. With rd=0, no stall.
- Branch_taken_i=1 with no hazard → IF_flush_o=1 for one cycle. With Branch_taken_i=1 during a load-use stall → IF_flush_o=0.
- MULDIV_LAT=4, ID_EX_MulDiv_i=1 → MulDiv_start_o pulses in cycle 0, freeze in cycles 0..3, MulDiv_sel_o=1 in cycle 4, then RUN.
- MULDIV_LAT=1 → freeze 1 cycle, MD_DONE next cycle. Two back-to-back muldiv ops → two separate start pulses, 2×LAT frozen cycles in total.
- rst_n_i low during MD_BUSY → outputs return to defaults immediately, no MulDiv_sel_o, state RUN after release.
- With HAZARD_PERF_EN: 1 load-use stall + 1 muldiv at LAT=4 + 2 flushes → Stall_cnt_o=5, Flush_cnt_o=2.
